// File: rtl/cr16_psr.sv
// CR16 processor status register: masked flag latch, one-deep interrupt shadow,
// and a registered Bcond/Jcond/Scond condition evaluator.
module cr16_psr #(
  parameter int P_WIDTH  = 16,
  parameter bit P_BYPASS = 1'b1
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic [4:0]         I_STATUS,
  input  logic [4:0]         I_STATUS_WE,
  input  logic               I_SAVE,
  input  logic               I_RESTORE,
  input  logic [3:0]         I_COND,
  input  logic               I_COND_VALID,
  output logic [4:0]         O_PSR,
  output logic               O_SHADOW_VALID,
  output logic               O_TAKEN,
  output logic               O_TAKEN_VALID,
  output logic [P_WIDTH-1:0] O_SCOND,
  output logic               O_FAULT
);

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  logic [4:0] r_psr;
  logic [4:0] r_shadow;
  logic       r_shadow_valid;
  logic       r_taken;
  logic       r_taken_valid;
  logic       r_fault;

  logic       w_restore_ok;
  logic [4:0] w_psr_n;
  logic [4:0] w_flags;
  logic       w_cond_true;

  // A restore only wins when the shadow actually holds something; otherwise the
  // write mask still applies and the attempt is reported as a fault.
  assign w_restore_ok = I_RESTORE & r_shadow_valid;
  assign w_psr_n      = w_restore_ok ? r_shadow
                                     : ((I_STATUS_WE & I_STATUS) | (~I_STATUS_WE & r_psr));
  assign w_flags      = P_BYPASS ? w_psr_n : r_psr;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cond_true = 1'b0;
    case (I_COND)
      4'd0:  w_cond_true =  w_flags[FLAG_Z];
      4'd1:  w_cond_true = ~w_flags[FLAG_Z];
      4'd2:  w_cond_true =  w_flags[FLAG_C];
      4'd3:  w_cond_true = ~w_flags[FLAG_C];
      4'd4:  w_cond_true =  w_flags[FLAG_L];
      4'd5:  w_cond_true = ~w_flags[FLAG_L];
      4'd6:  w_cond_true =  w_flags[FLAG_N];
      4'd7:  w_cond_true = ~w_flags[FLAG_N];
      4'd8:  w_cond_true =  w_flags[FLAG_F];
      4'd9:  w_cond_true = ~w_flags[FLAG_F];
      4'd10: w_cond_true = ~w_flags[FLAG_L] & ~w_flags[FLAG_Z];
      4'd11: w_cond_true =  w_flags[FLAG_L] |  w_flags[FLAG_Z];
      4'd12: w_cond_true = ~w_flags[FLAG_N] & ~w_flags[FLAG_Z];
      4'd13: w_cond_true =  w_flags[FLAG_N] |  w_flags[FLAG_Z];
      4'd14: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values (the save/restore swap depends on it).
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_psr          <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_taken        <= 1'b0;
      r_taken_valid  <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_psr <= w_psr_n;
      if (I_SAVE) begin
        r_shadow       <= r_psr;
        r_shadow_valid <= 1'b1;
      end else if (w_restore_ok) begin
        r_shadow_valid <= 1'b0;
      end
      r_fault       <= I_RESTORE & ~r_shadow_valid;
      r_taken_valid <= I_COND_VALID;
      if (I_COND_VALID) begin
        r_taken <= w_cond_true;
      end
    end
  end

  assign O_PSR          = r_psr;
  assign O_SHADOW_VALID = r_shadow_valid;
  assign O_TAKEN        = r_taken;
  assign O_TAKEN_VALID  = r_taken_valid;
  assign O_SCOND        = {{(P_WIDTH-1){1'b0}}, r_taken};
  assign O_FAULT        = r_fault;

endmodule

// File: tb/tb_cr16_psr.sv
// Self-checking bench for cr16_psr: a bypass and a non-bypass instance share
// stimulus and are compared every cycle against a flag-level reference model.
module tb_cr16_psr;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  status, status_we;
  logic        save, restore;
  logic [3:0]  cond;
  logic        cond_valid;

  logic [4:0]  b1_psr, b0_psr;
  logic        b1_shv, b0_shv, b1_taken, b0_taken, b1_tv, b0_tv, b1_fault, b0_fault;
  logic [15:0] b1_scond, b0_scond;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [4:0] m_psr, m_sh;
  logic       m_shv, m_fault, m_tv, m_taken1, m_taken0;

  always #5 clk = ~clk;

  cr16_psr #(.P_WIDTH(16), .P_BYPASS(1'b1)) u_byp (
    .I_CLK(clk), .I_RESET(reset), .I_STATUS(status), .I_STATUS_WE(status_we),
    .I_SAVE(save), .I_RESTORE(restore), .I_COND(cond), .I_COND_VALID(cond_valid),
    .O_PSR(b1_psr), .O_SHADOW_VALID(b1_shv), .O_TAKEN(b1_taken),
    .O_TAKEN_VALID(b1_tv), .O_SCOND(b1_scond), .O_FAULT(b1_fault));

  cr16_psr #(.P_WIDTH(16), .P_BYPASS(1'b0)) u_nobyp (
    .I_CLK(clk), .I_RESET(reset), .I_STATUS(status), .I_STATUS_WE(status_we),
    .I_SAVE(save), .I_RESTORE(restore), .I_COND(cond), .I_COND_VALID(cond_valid),
    .O_PSR(b0_psr), .O_SHADOW_VALID(b0_shv), .O_TAKEN(b0_taken),
    .O_TAKEN_VALID(b0_tv), .O_SCOND(b0_scond), .O_FAULT(b0_fault));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Condition table written from the flag names: C=0 L=1 F=2 Z=3 N=4.
  function automatic bit cond_ref(int code, logic [4:0] f);
    bit c = f[0];
    bit l = f[1];
    bit ff = f[2];
    bit z = f[3];
    bit n = f[4];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return l;
      5:  return !l;
      6:  return n;
      7:  return !n;
      8:  return ff;
      9:  return !ff;
      10: return !l && !z;
      11: return l || z;
      12: return !n && !z;
      13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic compare_all();
    check("b1_psr",   {27'd0, b1_psr},   {27'd0, m_psr});
    check("b1_shv",   {31'd0, b1_shv},   {31'd0, m_shv});
    check("b1_tv",    {31'd0, b1_tv},    {31'd0, m_tv});
    check("b1_taken", {31'd0, b1_taken}, {31'd0, m_taken1});
    check("b1_scond", {16'd0, b1_scond}, {31'd0, m_taken1});
    check("b1_fault", {31'd0, b1_fault}, {31'd0, m_fault});
    check("b0_psr",   {27'd0, b0_psr},   {27'd0, m_psr});
    check("b0_tv",    {31'd0, b0_tv},    {31'd0, m_tv});
    check("b0_taken", {31'd0, b0_taken}, {31'd0, m_taken0});
    check("b0_scond", {16'd0, b0_scond}, {31'd0, m_taken0});
    check("b0_fault", {31'd0, b0_fault}, {31'd0, m_fault});
  endtask

  // Advance one clock: model the edge from the current inputs, then compare.
  task automatic tick();
    logic [4:0] n_psr, n_sh;
    logic       n_shv, n_fault, n_tv, n_t1, n_t0;
    bit         do_restore;
    if (reset) begin
      n_psr = 0; n_sh = 0; n_shv = 0; n_fault = 0; n_tv = 0; n_t1 = 0; n_t0 = 0;
    end else begin
      do_restore = restore && m_shv;
      if (do_restore) n_psr = m_sh;
      else for (int i = 0; i < 5; i++) n_psr[i] = status_we[i] ? status[i] : m_psr[i];
      n_sh  = save ? m_psr : m_sh;
      n_shv = save ? 1'b1 : (do_restore ? 1'b0 : m_shv);
      n_fault = restore && !m_shv;
      n_tv  = cond_valid;
      n_t1  = cond_valid ? cond_ref(int'(cond), n_psr) : m_taken1;
      n_t0  = cond_valid ? cond_ref(int'(cond), m_psr) : m_taken0;
    end
    @(posedge clk);
    #1;
    m_psr = n_psr; m_sh = n_sh; m_shv = n_shv; m_fault = n_fault;
    m_tv = n_tv; m_taken1 = n_t1; m_taken0 = n_t0;
    compare_all();
  endtask

  task automatic idle();
    reset = 0; status = 0; status_we = 0; save = 0; restore = 0; cond = 0; cond_valid = 0;
  endtask

  task automatic write_psr(input logic [4:0] v);
    idle(); status = v; status_we = 5'b11111; tick();
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  initial begin
    m_psr = 0; m_sh = 0; m_shv = 0; m_fault = 0; m_tv = 0; m_taken1 = 0; m_taken0 = 0;
    idle();

    // Reset with random other inputs for three cycles.
    for (int i = 0; i < 3; i++) begin
      reset = 1; status = 5'($urandom); status_we = 5'($urandom);
      save = 1'($urandom); restore = 1'($urandom);
      cond = 4'($urandom); cond_valid = 1'b1;
      tick();
      check("rst_tv", {31'd0, b1_tv}, 32'd0);
      check("rst_psr", {27'd0, b1_psr}, 32'd0);
    end

    // Masked write then hold.
    idle(); status = 5'b11111; status_we = 5'b01001; tick();
    check("mask_psr", {27'd0, b1_psr}, 32'b01001);
    idle(); tick(); tick();
    check("mask_hold", {27'd0, b1_psr}, 32'b01001);

    // Bypass vs non-bypass on same-cycle write.
    write_psr(5'b00000);
    idle(); status_we = 5'b01000; status = 5'b01000; cond = 4'd0; cond_valid = 1; tick();
    check("byp_taken", {31'd0, b1_taken}, 32'd1);
    check("byp_scond", {16'd0, b1_scond}, 32'h0001);
    check("nobyp_taken", {31'd0, b0_taken}, 32'd0);
    idle(); tick();
    check("tv_pulse", {31'd0, b1_tv}, 32'd0);
    check("taken_hold", {31'd0, b1_taken}, 32'd1);

    // Full table: all PSR values x all conditions.
    for (int p = 0; p < 32; p++) begin
      for (int c = 0; c < 16; c++) begin
        write_psr(5'(p));
        idle(); cond = 4'(c); cond_valid = 1; tick();
      end
    end

    // Save / restore / fault.
    do_reset();
    write_psr(5'b10010);
    idle(); save = 1; tick();
    write_psr(5'b00001);
    idle(); restore = 1; status_we = 5'b11111; status = 5'b00000; tick();
    check("rest_psr", {27'd0, b1_psr}, 32'b10010);
    check("rest_shv", {31'd0, b1_shv}, 32'd0);
    idle(); restore = 1; tick();
    check("fault_pulse", {31'd0, b1_fault}, 32'd1);
    check("fault_psr", {27'd0, b1_psr}, 32'b10010);
    idle(); tick();
    check("fault_clear", {31'd0, b1_fault}, 32'd0);

    // Swap.
    do_reset();
    write_psr(5'b01000);
    idle(); save = 1; tick();
    write_psr(5'b00100);
    idle(); save = 1; restore = 1; tick();
    check("swap_psr", {27'd0, b1_psr}, 32'b01000);
    check("swap_shv", {31'd0, b1_shv}, 32'd1);
    idle(); restore = 1; tick();
    check("swap_back", {27'd0, b1_psr}, 32'b00100);

    // Random traffic, including occasional reset mid-query.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      status     = 5'($urandom);
      status_we  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      save       = ($urandom_range(0, 5) == 0);
      restore    = ($urandom_range(0, 5) == 0);
      cond       = 4'($urandom);
      cond_valid = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cr16_psr.md
# cr16_psr

Processor status register and condition evaluator for the CR16 datapath: the consumer of the 5-bit ALU status vector. Latches ALU flags under per-flag write masks, keeps a one-deep shadow copy for interrupt entry/exit, and answers Bcond/Jcond/Scond condition queries with a registered taken/not-taken result one cycle later. Sits between the ALU status output and the branch/PC control logic.

## Interface
- P_WIDTH, 16, width of O_SCOND (Scond result written to a register)
- P_BYPASS, 1, 1: queries see flags written in the same cycle; 0: queries see the current PSR only
- I_CLK  input  1  clock, all state updates on rising edge
- I_RESET  input  1  synchronous, active-high reset
- I_STATUS  input  5  ALU flags: [0] C carry, [1] L low, [2] F flag, [3] Z zero, [4] N negative
- I_STATUS_WE  input  5  per-flag write mask; bit i set updates PSR[i] from I_STATUS[i]
- I_SAVE  input  1  copy PSR to shadow (interrupt entry)
- I_RESTORE  input  1  copy shadow to PSR (interrupt return)
- I_COND  input  4  condition code of the query
- I_COND_VALID  input  1  query strobe
- O_PSR  output  5  current architectural flags
- O_SHADOW_VALID  output  1  shadow holds a saved value
- O_TAKEN  output  1  registered query result
- O_TAKEN_VALID  output  1  one-cycle pulse marking O_TAKEN valid
- O_SCOND  output  P_WIDTH  zero-extended O_TAKEN, valid with O_TAKEN_VALID
- O_FAULT  output  1  one-cycle pulse: restore requested with empty shadow

## Operation
- Next-PSR (psr_n) per cycle, priority order:
  - I_RESTORE and O_SHADOW_VALID: psr_n = shadow; I_STATUS_WE ignored this cycle.
  - else: psr_n[i] = I_STATUS_WE[i] ? I_STATUS[i] : PSR[i].
- I_RESTORE with O_SHADOW_VALID=0: PSR follows the mask rule, O_FAULT pulses, shadow unchanged.
- I_SAVE: shadow <= PSR (pre-update value, never psr_n); O_SHADOW_VALID <= 1.
- Valid restore without save: O_SHADOW_VALID <= 0. Save and valid restore together: swap (PSR <= shadow, shadow <= old PSR, valid stays 1).
- Condition table, evaluated on psr_n if P_BYPASS=1, else PSR:
  - 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 4 HI L=1; 5 LS L=0; 6 GT N=1; 7 LE N=0
  - 8 FS F=1; 9 FC F=0; 10 LO L=0&Z=0; 11 HS L=1|Z=1; 12 LT N=0&Z=0; 13 GE N=1|Z=1
  - 14 UC always 1; 15 never 0
- I_COND_VALID=0: O_TAKEN holds last value; O_SCOND holds.
- Flags are bit-exact; no arithmetic beyond the table. O_SCOND[P_WIDTH-1:1] always 0.

## Timing
- Reset (I_RESET high at edge): PSR=0, shadow=0, O_SHADOW_VALID=0, O_TAKEN=0, O_TAKEN_VALID=0, O_SCOND=0, O_FAULT=0. Reset overrides every other input in that cycle.
- Flag write: visible on O_PSR the cycle after the edge sampling I_STATUS_WE.
- Query latency: 1 cycle. Query at edge k -> O_TAKEN/O_SCOND/O_TAKEN_VALID at k+1. Back-to-back queries give back-to-back results; no stall, no ready signal.
- O_TAKEN_VALID, O_FAULT: high exactly one cycle per event, low otherwise.
- Reset mid-query: pending result discarded, O_TAKEN_VALID low next cycle.
- Mask 0 with no restore: PSR holds indefinitely.

## Test plan
- Reset: drive random inputs with I_RESET=1 for 3 cycles -> all outputs 0 one cycle after first reset edge; O_TAKEN_VALID never pulses.
- Masked write: PSR=0, I_STATUS=5'b11111, I_STATUS_WE=5'b01001 -> O_PSR=5'b01001; then WE=0, STATUS=0 -> O_PSR stays 5'b01001.
- Bypass: P_BYPASS=1, PSR=0, same cycle WE=5'b01000, STATUS[3]=1, I_COND=0 (EQ) -> O_TAKEN=1, O_SCOND=16'h0001 next cycle; P_BYPASS=0 same stimulus -> O_TAKEN=0.
- Full table: for all 32 PSR values x 16 conds, set PSR then query -> O_TAKEN matches table; cond 14 always 1, cond 15 always 0.
- Save/restore: PSR=5'b10010, I_SAVE, write PSR=5'b00001, I_RESTORE with WE=5'b11111 STATUS=0 -> O_PSR=5'b10010, O_SHADOW_VALID=0; second I_RESTORE -> O_FAULT pulse, O_PSR unchanged.
- Swap: PSR=5'b00100, shadow=5'b01000 valid, I_SAVE+I_RESTORE -> O_PSR=5'b01000, next restore yields 5'b00100.
